// File: rtl/tetromino_row_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetromino_row_streamer_pkg
// Purpose  : Shared tetromino definitions: piece index type and encoding,
//            packed 4-rotation shape type, the seven shape constants and
//            the streamer FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package tetromino_row_streamer_pkg;

  localparam int TETRO_GRID       = 4;
  localparam int TETRO_NUM_ROT    = 4;
  localparam int TETRO_NUM_PIECES = 7;
  localparam int TETRO_IDX_W      = 3;

  typedef logic [TETRO_IDX_W-1:0] tetromino_idx_t;

  // Rotation 0 occupies the MSB group, row 0 leads within a rotation and
  // the leftmost column is the MSB of each row.
  typedef logic [TETRO_NUM_ROT*TETRO_GRID*TETRO_GRID-1:0] tetromino_t;

  localparam tetromino_idx_t TETROMINO_I_IDX = 3'd0;
  localparam tetromino_idx_t TETROMINO_J_IDX = 3'd1;
  localparam tetromino_idx_t TETROMINO_L_IDX = 3'd2;
  localparam tetromino_idx_t TETROMINO_O_IDX = 3'd3;
  localparam tetromino_idx_t TETROMINO_S_IDX = 3'd4;
  localparam tetromino_idx_t TETROMINO_T_IDX = 3'd5;
  localparam tetromino_idx_t TETROMINO_Z_IDX = 3'd6;

  // Each 16-bit group is one rotation: four nibbles, top row first.
  localparam tetromino_t TETROMINO_I = 64'h0F00_2222_00F0_4444;
  localparam tetromino_t TETROMINO_J = 64'h08E0_0644_00E2_044C;
  localparam tetromino_t TETROMINO_L = 64'h02E0_0446_00E8_0C44;
  localparam tetromino_t TETROMINO_O = 64'h0660_0660_0660_0660;
  localparam tetromino_t TETROMINO_S = 64'h06C0_0462_006C_08C4;
  localparam tetromino_t TETROMINO_T = 64'h04E0_0464_00E4_04C4;
  localparam tetromino_t TETROMINO_Z = 64'h0C60_0264_00C6_04C8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/tetromino_row_streamer_get_tetromino_info.sv
`default_nettype none
// ============================================================================
// Module   : get_tetromino_info
// Purpose  : Combinational piece lookup returning all rotations of the
//            selected tetromino plus a flag marking a legal index.
// Revision : 1.0 - initial release
// ============================================================================
module get_tetromino_info
  import tetromino_row_streamer_pkg::*;
(
  input  tetromino_idx_t idx,
  output tetromino_t     shape,
  output logic           legal
);

  // Index decode; unknown indices return an empty shape flagged illegal.
  always_comb begin
    shape = '0;
    legal = 1'b1;
    case (idx)
      TETROMINO_I_IDX: shape = TETROMINO_I;
      TETROMINO_J_IDX: shape = TETROMINO_J;
      TETROMINO_L_IDX: shape = TETROMINO_L;
      TETROMINO_O_IDX: shape = TETROMINO_O;
      TETROMINO_S_IDX: shape = TETROMINO_S;
      TETROMINO_T_IDX: shape = TETROMINO_T;
      TETROMINO_Z_IDX: shape = TETROMINO_Z;
      default:         legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tetromino_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tetromino_row_streamer
// Purpose  : Accepts a piece/rotation/mirror request, then streams the shape
//            one row per beat with a running cell count and column mask
//            presented on the final beat.
// Revision : 1.0 - initial release
// ============================================================================
module tetromino_row_streamer
  import tetromino_row_streamer_pkg::*;
#(
  parameter  int GRID       = TETRO_GRID,
  parameter  int NUM_ROT    = TETRO_NUM_ROT,
  parameter  int NUM_PIECES = TETRO_NUM_PIECES,
  parameter  int IDX_W      = TETRO_IDX_W,
  localparam int ROT_W      = (NUM_ROT > 1) ? $clog2(NUM_ROT) : 1,
  localparam int ROW_W      = (GRID > 1) ? $clog2(GRID) : 1,
  localparam int CNT_W      = $clog2(GRID*GRID+1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [ROT_W-1:0] req_rot,
  input  logic             req_mirror,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [GRID-1:0]  row_data,
  output logic [ROW_W-1:0] row_num,
  output logic             row_last,
  output logic             row_err,
  output logic [CNT_W-1:0] sum_count,
  output logic [GRID-1:0]  sum_colmask
);

  localparam int GG = GRID * GRID;

  stream_state_t    r_state;
  logic             r_req_ready;
  logic             r_row_valid;
  logic [IDX_W-1:0] r_idx;
  logic [ROT_W-1:0] r_rot;
  logic             r_mirror;
  logic             r_err;
  logic [GG-1:0]    r_shape;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_acc_count;
  logic [GRID-1:0]  r_acc_mask;

  tetromino_t       w_table;
  logic             w_legal_idx;
  logic             w_illegal;
  logic [GG-1:0]    w_slice;
  logic [GRID-1:0]  w_row_raw;
  logic [GRID-1:0]  w_row_data;
  logic             w_last;

  function automatic logic [CNT_W-1:0] popcount(input logic [GRID-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < GRID; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [GRID-1:0] bit_reverse(input logic [GRID-1:0] v);
    logic [GRID-1:0] r;
    r = '0;
    for (int i = 0; i < GRID; i++) r[i] = v[GRID-1-i];
    return r;
  endfunction

  get_tetromino_info u_lookup (
    .idx   (tetromino_idx_t'(r_idx)),
    .shape (w_table),
    .legal (w_legal_idx)
  );

  // Pick the rotation slice and flag out-of-range index/rotation as illegal.
  always_comb begin
    w_illegal = !w_legal_idx
              || (32'(r_idx) >= NUM_PIECES)
              || (32'(r_rot) >= NUM_ROT);
    w_slice   = w_illegal ? '0 : w_table[(NUM_ROT-1-int'(r_rot))*GG +: GG];
  end

  // Present the current row (optionally mirrored) and the last-beat sums,
  // forcing everything to zero while no beat is offered.
  always_comb begin
    w_row_raw   = r_shape[(GRID-1-int'(r_row))*GRID +: GRID];
    w_row_data  = '0;
    if (r_row_valid) w_row_data = r_mirror ? bit_reverse(w_row_raw) : w_row_raw;
    w_last      = r_row_valid && (r_row == ROW_W'(GRID-1));
    row_data    = w_row_data;
    row_num     = r_row_valid ? r_row : '0;
    row_last    = w_last;
    row_err     = r_row_valid && r_err;
    sum_count   = w_last ? (r_acc_count + popcount(w_row_data)) : '0;
    sum_colmask = w_last ? (r_acc_mask | w_row_data) : '0;
    req_ready   = r_req_ready;
    row_valid   = r_row_valid;
  end

  // Request capture, shape load and row-stream sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_row_valid <= 1'b0;
      r_idx       <= '0;
      r_rot       <= '0;
      r_mirror    <= 1'b0;
      r_err       <= 1'b0;
      r_shape     <= '0;
      r_row       <= '0;
      r_acc_count <= '0;
      r_acc_mask  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_idx       <= req_idx;
            r_rot       <= req_rot;
            r_mirror    <= req_mirror;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shape     <= w_slice;
          r_err       <= w_illegal;
          r_acc_count <= '0;
          r_acc_mask  <= '0;
          r_row       <= '0;
          r_row_valid <= 1'b1;
          r_state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (row_ready) begin
            r_acc_count <= r_acc_count + popcount(w_row_data);
            r_acc_mask  <= r_acc_mask | w_row_data;
            if (w_last) begin
              r_row_valid <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        default: begin
          r_row_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetromino_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetromino_row_streamer
// Purpose  : Directed self-checking bench for tetromino_row_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetromino_row_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_idx;
  logic [1:0] req_rot;
  logic       req_mirror;
  logic       row_valid;
  logic       row_ready;
  logic [3:0] row_data;
  logic [1:0] row_num;
  logic       row_last;
  logic       row_err;
  logic [4:0] sum_count;
  logic [3:0] sum_colmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tetromino_row_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_idx     (req_idx),
    .req_rot     (req_rot),
    .req_mirror  (req_mirror),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_num     (row_num),
    .row_last    (row_last),
    .row_err     (row_err),
    .sum_count   (sum_count),
    .sum_colmask (sum_colmask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(row_valid), 32'd0);
    chk({tag, "_data"},  32'(row_data), 32'd0);
    chk({tag, "_num"},   32'(row_num), 32'd0);
    chk({tag, "_last"},  32'(row_last), 32'd0);
    chk({tag, "_err"},   32'(row_err), 32'd0);
    chk({tag, "_cnt"},   32'(sum_count), 32'd0);
    chk({tag, "_mask"},  32'(sum_colmask), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge two cycles after
  // the accepting rising edge, where the first beat must be present.
  task automatic issue(input string tag, input logic [2:0] idx,
                       input logic [1:0] rot, input logic mir);
    int waited;
    waited     = 0;
    req_idx    = idx;
    req_rot    = rot;
    req_mirror = mir;
    req_valid  = 1'b1;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_accept_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_load_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_load_valid"}, 32'(row_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 32'(row_valid), 32'd1);
  endtask

  // Checks four beats; rows is four nibbles, top row first.
  task automatic stream(input string tag, input logic [15:0] rows, input logic err,
                        input logic [4:0] cnt, input logic [3:0] mask,
                        input int stall_row, input int stall_n);
    logic [3:0] er;
    for (int r = 0; r < 4; r++) begin
      er = rows[15-4*r -: 4];
      chk($sformatf("%s_r%0d_valid", tag, r), 32'(row_valid), 32'd1);
      chk($sformatf("%s_r%0d_data", tag, r),  32'(row_data), 32'(er));
      chk($sformatf("%s_r%0d_num", tag, r),   32'(row_num), 32'(r));
      chk($sformatf("%s_r%0d_last", tag, r),  32'(row_last), (r == 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s_r%0d_err", tag, r),   32'(row_err), 32'(err));
      chk($sformatf("%s_r%0d_busy", tag, r),  32'(req_ready), 32'd0);
      chk($sformatf("%s_r%0d_cnt", tag, r),   32'(sum_count), (r == 3) ? 32'(cnt) : 32'd0);
      chk($sformatf("%s_r%0d_mask", tag, r),  32'(sum_colmask), (r == 3) ? 32'(mask) : 32'd0);
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          chk($sformatf("%s_stall%0d_valid", tag, k), 32'(row_valid), 32'd1);
          chk($sformatf("%s_stall%0d_data", tag, k),  32'(row_data), 32'(er));
          chk($sformatf("%s_stall%0d_num", tag, k),   32'(row_num), 32'(r));
        end
        row_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_done_valid"}, 32'(row_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_idx    = 3'd0;
    req_rot    = 2'd0;
    req_mirror = 1'b0;
    row_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk_quiet("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(row_valid), 32'd0);

    // I, rot 0, no mirror
    issue("i0", 3'd0, 2'd0, 1'b0);
    stream("i0", 16'h0F00, 1'b0, 5'd4, 4'hF, -1, 0);

    // J, rot 0, mirrored
    issue("j0m", 3'd1, 2'd0, 1'b1);
    stream("j0m", 16'h0170, 1'b0, 5'd4, 4'h7, -1, 0);

    // T, rot 1, consumer stalls three cycles on row 2
    issue("t1", 3'd5, 2'd1, 1'b0);
    stream("t1", 16'h0464, 1'b0, 5'd4, 4'h6, 2, 3);

    // Illegal index
    issue("bad", 3'd7, 2'd0, 1'b0);
    stream("bad", 16'h0000, 1'b1, 5'd0, 4'h0, -1, 0);

    // O rot 0 with S rot 2 held waiting behind it
    issue("o0", 3'd3, 2'd0, 1'b0);
    req_idx   = 3'd4;
    req_rot   = 2'd2;
    req_valid = 1'b1;
    stream("o0", 16'h0660, 1'b0, 5'd4, 4'h6, -1, 0);
    issue("s2", 3'd4, 2'd2, 1'b0);
    stream("s2", 16'h006C, 1'b0, 5'd4, 4'hE, -1, 0);

    // Reset while Z row 1 is pending
    issue("z0", 3'd6, 2'd0, 1'b0);
    @(negedge clk);
    row_ready = 1'b0;
    chk("z0_pend_num",  32'(row_num), 32'd1);
    chk("z0_pend_data", 32'(row_data), 32'hC);
    #2 reset = 1'b1;
    #1;
    chk_quiet("midrst");
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    row_ready = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(req_ready), 32'd1);
    chk("postrst_valid", 32'(row_valid), 32'd0);
    issue("z0b", 3'd6, 2'd0, 1'b0);
    stream("z0b", 16'h0C60, 1'b0, 5'd4, 4'hE, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
